// File: rtl/sap3_io_pkg.sv
// Shared definitions for the SAP-3 I/O path: UART state encoding,
// decoded port addresses and the default serial bit period.
`timescale 1ns/1ps
package sap3_io_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    localparam logic [15:0] UART_TX_ADDR = 16'h0001;

    localparam int UART_CLK_DIV_DEFAULT = 16;

endpackage

// File: rtl/io_uart_tx_if.sv
// Output-write bus from the I/O controller to a memory-mapped port.
//
// Handshake: wr_stb is a one-cycle valid qualifying out_address_bus and
// out_data_bus in the same cycle. There is no ready; the receiving port
// always samples the write and is responsible for reporting a drop.
`timescale 1ns/1ps
interface io_uart_tx_if;
    logic        wr_stb;
    logic [15:0] out_address_bus;
    logic [7:0]  out_data_bus;

    modport master (
        output wr_stb,
        output out_address_bus,
        output out_data_bus
    );

    modport slave (
        input wr_stb,
        input out_address_bus,
        input out_data_bus
    );
endinterface

// File: rtl/io_fifo.sv
// Small synchronous FIFO. A push while full is still accepted when a pop
// happens in the same cycle, because the head slot is freed on that edge.
`timescale 1ns/1ps
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     push_ok,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_pop;
    logic             do_push;

    // Status and accepted-operation decode from the registered count.
    always_comb begin
        full     = (cnt == (AW+1)'(DEPTH));
        empty    = (cnt == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        push_ok  = do_push;
        pop_data = mem[rptr];
        count    = cnt;
    end

    // Storage array; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: decodes writes to PORT_ADDR, queues the
// bytes and shifts them out as 8N1 frames, LSB first. tx is registered from
// the next-state logic so the start bit begins on the popping edge.
`timescale 1ns/1ps
module io_uart_tx
    import sap3_io_pkg::*;
#(
    parameter logic [15:0] PORT_ADDR  = UART_TX_ADDR,
    parameter int          CLK_DIV    = UART_CLK_DIV_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    io_uart_tx_if.slave                   bus,
    input  logic                          ovf_clr,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          overflow,
    output logic [1:0]                    dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_count
);
    localparam int CW = $clog2(CLK_DIV);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = UART_IDLE;
    localparam logic [1:0] S_START = UART_START;
    localparam logic [1:0] S_DATA  = UART_DATA;
    localparam logic [1:0] S_STOP  = UART_STOP;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [2:0]    idx;
    logic [2:0]    idx_nx;
    logic [7:0]    sh;
    logic [7:0]    sh_nx;
    logic          tx_q;
    logic          tx_nx;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          ovf_set;
    logic [7:0]    fifo_head;

    io_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (bus.out_data_bus),
        .pop       (pop),
        .pop_data  (fifo_head),
        .push_ok   (push_ok),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (dbg_fifo_count)
    );

    // Address decode; a decoded write the FIFO cannot take is a drop.
    always_comb begin
        push_req = bus.wr_stb && (bus.out_address_bus == PORT_ADDR);
        ovf_set  = push_req && !push_ok;
    end

    // Frame sequencer: next state, baud count, bit index, shifter and line.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        sh_nx    = sh;
        tx_nx    = tx_q;
        pop      = 1'b0;
        case (state)
            S_IDLE: begin
                tx_nx = 1'b1;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    sh_nx    = fifo_head;
                    cnt_nx   = BAUD_LAST;
                    state_nx = S_START;
                    tx_nx    = 1'b0;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    state_nx = S_DATA;
                    idx_nx   = 3'd0;
                    cnt_nx   = BAUD_LAST;
                    tx_nx    = sh[0];
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    cnt_nx = BAUD_LAST;
                    sh_nx  = {1'b0, sh[7:1]};
                    if (idx == 3'd7) begin
                        state_nx = S_STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        idx_nx = idx + 3'd1;
                        tx_nx  = sh[1];
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_STOP: begin
                tx_nx = 1'b1;
                if (cnt == '0) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                tx_nx    = 1'b1;
            end
        endcase
    end

    // Sequencer registers; reset forces the line high mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= 3'd0;
            sh    <= 8'd0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            sh    <= sh_nx;
            tx_q  <= tx_nx;
        end
    end

    // Sticky drop flag; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Status outputs.
    always_comb begin
        tx        = tx_q;
        tx_busy   = (state != S_IDLE);
        dbg_state = state;
    end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped serial output port for the SAP-3 I/O path. It sits directly downstream of the I/O controller and consumes that block's latched 16-bit output address and 8-bit output data. When a data write targets this port's address, the byte is queued in a small FIFO. Queued bytes are shifted out on `tx` as 8N1 UART frames, LSB first.

## Interface
Parameters:
- `PORT_ADDR`, default 16'h0001: output address decoded as this port.
- `CLK_DIV`, default 16: clocks per serial bit, ≥ 2.
- `FIFO_DEPTH`, default 4: queue entries, a power of two, ≥ 2.

Ports:
- `clk`  in  1: single system clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `wr_stb`  in  1: one-cycle pulse asserted the cycle after the I/O controller's data register loads. `out_data_bus` already holds the new byte.
- `out_address_bus`  in  16: latched output address from the I/O controller.
- `out_data_bus`  in  8: latched output data from the I/O controller.
- `ovf_clr`  in  1: synchronous clear of `overflow`.
- `tx`  out  1: serial line, registered, idle high.
- `tx_busy`  out  1: high whenever state ≠ IDLE.
- `fifo_full`  out  1: count == FIFO_DEPTH.
- `fifo_empty`  out  1: count == 0.
- `overflow`  out  1: sticky; a write was dropped.

## Operation
- Push condition: `wr_stb && out_address_bus == PORT_ADDR`.
  - `out_data_bus` is enqueued if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set.
- Writes to any other address are ignored entirely.
- `overflow`: `ovf_clr` clears it. If a set condition and `ovf_clr` occur in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx` = 1. If the FIFO is not empty, pop the head into shift register `sh[7:0]`, load the baud counter with CLK_DIV-1, and go to START.
  - START: `tx` = 0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx` = `sh[0]` for CLK_DIV cycles per bit. At the end of each bit, shift right and increment the index. After bit 7, go to STOP.
  - STOP: `tx` = 1 for CLK_DIV cycles, then go to IDLE.
- Baud counter counts down from CLK_DIV-1; reaching 0 marks the end of a bit period.
- The bit index is 3 bits and does not wrap within a frame.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.
- Reset, asynchronous at any point including mid-frame:
  - state = IDLE, FIFO emptied, counters = 0, `overflow` = 0.
  - `tx` = 1 immediately, so a frame in progress is aborted with the line high.

## Timing
Output values in reset: `tx`=1, `tx_busy`=0, `fifo_full`=0, `fifo_empty`=1, `overflow`=0.

- Push latency: the byte is counted on the edge after `wr_stb`, so `fifo_empty` falls 1 cycle after `wr_stb`.
- Pop from IDLE happens on the first edge at which the FIFO is non-empty. The `tx` falling edge appears on that same edge, because `tx` is registered from the next state.
- First-byte latency: `wr_stb` to `tx` low = 2 cycles.
- Frame length: 10·CLK_DIV cycles from `tx` low until the end of the stop bit.
- Consecutive frames have exactly one IDLE cycle between them, so back-to-back frame period = 10·CLK_DIV+1 cycles.
- `tx_busy` rises with `tx` low and falls on the first IDLE cycle.
- `fifo_full` and `fifo_empty` are combinational from the registered count.

## Structure
- Shared package `sap3_io_pkg` holds:
  - the UART state enum (IDLE/START/DATA/STOP);
  - I/O port address constants (`UART_TX_ADDR` = 16'h0001);
  - the default CLK_DIV.
- Sub-module `io_fifo`: parameterised synchronous FIFO (width 8, depth FIFO_DEPTH) with push/pop/full/empty/count. It implements the simultaneous push+pop-when-full rule.
- The top level holds the address decode, the FSM, the baud counter, the shift register and `overflow`.

## Test plan
All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.
- Single write: reset release, then `wr_stb` with addr 16'h0001 and data 8'hA5.
  - `tx` low 2 cycles later.
  - Line then reads 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles.
  - `tx_busy` high for 40 cycles.
- Address filter: `wr_stb` with addr 16'h0002, data 8'hFF → `fifo_empty` stays 1, `tx` stays 1, `tx_busy` stays 0.
- Overflow: 6 strobes to 16'h0001 on consecutive cycles, data 8'h01–8'h06.
  - 5 bytes are accepted (the first pops immediately) and 8'h06 is dropped.
  - `overflow` = 1.
  - Frames 01–05 are sent with a period of 41 cycles.
  - `ovf_clr` then drives `overflow` to 0.
- Full with simultaneous pop: FIFO full, and a strobe arrives on the IDLE pop cycle → byte accepted, `overflow` stays 0, `fifo_full` stays 1.
- Reset mid-frame: assert `rst` during data bit 3 → `tx`=1 and `fifo_empty`=1 at once. After release, no further frame starts.
- Back-to-back: two bytes 8'h00 and 8'hFF queued → second start bit begins exactly 41 cycles after the first.
